pow_5_rr_arb_multi_cycle: RTL and testbench
===========================================

POW_5_RR_ARB_MULTI_CYCLE -- requirements
Module: pow_5_rr_arb_multi_cycle

Interface
REQ-001 The block SHALL have one parameter: w, default 8, data width of arguments and result.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the port clk_en, input, 1 bit: global enable; when low, all state holds.
REQ-005 The block SHALL have the port req0_vld, input, 1 bit: requester 0 has an argument.
REQ-006 The block SHALL have the port req0_arg, input, w bits: requester 0 argument.
REQ-007 The block SHALL have the port req0_rdy, output, 1 bit: requester 0 argument accepted this cycle.
REQ-008 The block SHALL have the ports req1_vld, req1_arg and req1_rdy, identical to requester 0 but for requester 1.
REQ-009 The block SHALL have the port res_vld, output, 1 bit: result available.
REQ-010 The block SHALL have the port res_id, output, 1 bit: index of the requester that owns res.
REQ-011 The block SHALL have the port res, output, w bits: arg^5 mod 2^w.
REQ-012 The block SHALL have the port res_rdy, input, 1 bit: consumer accepts the result.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, BUSY, DONE.
REQ-014 A transfer on requester i SHALL occur on an edge with clk_en=1, reqi_vld=1 and reqi_rdy=1.
REQ-015 A result transfer SHALL occur on an edge with clk_en=1, res_vld=1 and res_rdy=1.
REQ-016 reqi_rdy SHALL be combinational: 1 only when state=IDLE, clk_en=1, reqi_vld=1 and requester i holds the grant; at most one rdy is high per cycle.
REQ-017 Grant SHALL be round-robin:
- If only one requester is valid, it gets the grant.
- If both are valid, the grant goes to the requester not equal to last_id.
REQ-018 On a request transfer, the block SHALL:
- capture arg into arg_q and into acc;
- capture the winning index into id_q;
- clear the 2-bit cycle counter cnt;
- move to BUSY.
REQ-019 In BUSY, on each clk_en=1 edge, the block SHALL update acc <= (acc*arg_q) truncated to w bits and increment cnt.
- On the edge where cnt=3, state moves to DONE.
- acc then holds arg^5 mod 2^w.
REQ-020 Latency: res_vld SHALL rise exactly 4 enabled edges after the request-transfer edge.
REQ-021 In DONE, the block SHALL drive res_vld=1, res=acc and res_id=id_q, and hold all three stable until the result transfer.
REQ-022 On the result transfer, the block SHALL set last_id <= id_q and move to IDLE; no request is accepted on that same edge.
- Minimum issue interval is 6 enabled edges.
REQ-023 In IDLE and BUSY, res_vld SHALL be 0; res and res_id are don't-care but SHALL NOT change outside transfers.
REQ-024 With clk_en=0, the block SHALL hold FSM, acc, cnt, arg_q, id_q and last_id, keep res_vld at its current value, and force both rdy outputs to 0.
REQ-025 The block SHALL ignore reqi_vld while in BUSY or DONE; requesters keep vld high until they see rdy.

Reset
REQ-026 On an rst_n=0 edge (independent of clk_en), the block SHALL set:
- state=IDLE, cnt=0, acc=0, arg_q=0, id_q=0;
- last_id=1, so requester 0 wins the first tie;
- res_vld=0, res=0, res_id=0.
REQ-027 Reset mid-BUSY or mid-DONE SHALL abort the operation and drop the pending result without emitting it.

Verification
REQ-028 The bench SHALL drive req0 with arg=3 alone and res_rdy=1, and check: req0_rdy pulses once, then res_vld=1, res=243, res_id=0 four edges later, for one cycle.
REQ-029 The bench SHALL drive both requesters valid from reset (req0 arg=2, req1 arg=5), and check: req0 is served first (res=32, id 0), then req1 (res=53, id 1); then with both still valid, req0 is served next.
REQ-030 The bench SHALL hold res_rdy=0 for 10 cycles in DONE with arg=255, and check: res=255, res_id and res_vld are stable, no rdy is asserted, and IDLE is entered one edge after res_rdy=1.
REQ-031 The bench SHALL drop clk_en for 3 cycles during BUSY with arg=7, and check: acc is frozen and rdy=0; res=7^5 mod 256=167 arrives 3 cycles later than nominal.
REQ-032 The bench SHALL assert rst_n=0 for one edge at cnt=2 in BUSY, and check: res_vld=0, state IDLE, the next tie goes to requester 0, and the aborted result never appears.

Source files
------------

// File: rtl/pow_5_rr_arb_multi_cycle.sv
// pow_5_rr_arb_multi_cycle
//   Two-requester round-robin arbiter in front of a multi-cycle arg^5 unit.
//   A granted argument is raised to the fifth power by four sequential
//   multiplies (mod 2^w), and the result is held until the consumer takes it.
//
// Ports
//   clk, rst_n        : clock; synchronous active-low reset
//   clk_en            : global enable; low freezes all state and blocks rdy
//   reqN_vld/arg/rdy  : requester N handshake (rdy is combinational)
//   res_vld/res/res_id: result handshake with the owning requester index
//   res_rdy           : consumer accepts the result
module pow_5_rr_arb_multi_cycle #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         req0_vld,
  input  logic [w-1:0] req0_arg,
  output logic         req0_rdy,
  input  logic         req1_vld,
  input  logic [w-1:0] req1_arg,
  output logic         req1_rdy,
  output logic         res_vld,
  output logic         res_id,
  output logic [w-1:0] res,
  input  logic         res_rdy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [w-1:0] acc_q, acc_d;
  logic [w-1:0] arg_q, arg_d;
  logic         id_q, id_d;
  logic         last_id_q, last_id_d;
  logic         res_vld_q, res_vld_d;
  logic [w-1:0] res_q, res_d;
  logic         res_id_q, res_id_d;

  logic         gnt0, gnt1, accept;
  logic [w-1:0] prod;

  // On a tie the grant goes to whoever was not served last.
  assign gnt0   = req0_vld & (~req1_vld | last_id_q);
  assign gnt1   = req1_vld & (~req0_vld | ~last_id_q);
  assign accept = (state_q == IDLE) & clk_en;

  assign req0_rdy = accept & gnt0;
  assign req1_rdy = accept & gnt1;

  assign prod = acc_q * arg_q;

  assign res_vld = res_vld_q;
  assign res     = res_q;
  assign res_id  = res_id_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    arg_d     = arg_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    res_vld_d = res_vld_q;
    res_d     = res_q;
    res_id_d  = res_id_q;
    if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (req0_rdy | req1_rdy) begin
            arg_d   = req1_rdy ? req1_arg : req0_arg;
            acc_d   = arg_d;
            id_d    = req1_rdy;
            cnt_d   = 2'd0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          // Four multiplies take acc from arg^1 to arg^5; the last one is
          // also latched straight into the result register.
          acc_d = prod;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d   = DONE;
            res_vld_d = 1'b1;
            res_d     = prod;
            res_id_d  = id_q;
          end
        end
        DONE: begin
          // No request is taken on this edge: rdy only rises in IDLE.
          if (res_rdy) begin
            res_vld_d = 1'b0;
            last_id_d = id_q;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      acc_q     <= '0;
      arg_q     <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;   // requester 0 wins the first tie
      res_vld_q <= 1'b0;
      res_q     <= '0;
      res_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      arg_q     <= arg_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      res_id_q  <= res_id_d;
    end
  end

endmodule

// File: tb/tb_pow_5_rr_arb_multi_cycle.sv
// Bench for pow_5_rr_arb_multi_cycle: table of single-requester vectors,
// directed arbitration / stall / abort sequences, and a scoreboard that
// predicts every result when its request is accepted.
module tb_pow_5_rr_arb_multi_cycle;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_en = 1'b0;
  logic         req0_vld = 1'b0, req1_vld = 1'b0, res_rdy = 1'b0;
  logic [W-1:0] req0_arg = '0, req1_arg = '0;
  logic         req0_rdy, req1_rdy, res_vld, res_id;
  logic [W-1:0] res;

  always #5 clk = ~clk;

  pow_5_rr_arb_multi_cycle #(.w(W)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req0_vld(req0_vld), .req0_arg(req0_arg), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_arg(req1_arg), .req1_rdy(req1_rdy),
    .res_vld(res_vld), .res_id(res_id), .res(res), .res_rdy(res_rdy)
  );

  typedef struct { logic id; logic [W-1:0] res; int t; } exp_t;
  typedef struct { logic id; logic [W-1:0] arg; logic [W-1:0] exp; } vec_t;

  exp_t         sb[$];
  logic         glog[$];   // grant order
  logic [W:0]   rlog[$];   // {res_id, res} of completed results
  int           checks = 0, failures = 0;
  int           en_cnt = 0, cyc_n = 0;
  logic         prev_vld = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pow5(input logic [W-1:0] a);
    longint unsigned p = 1;
    for (int k = 0; k < 5; k++) p = p * a;
    return p[W-1:0];
  endfunction

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rst_n && clk_en) en_cnt <= en_cnt + 1;
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_vld <= 1'b0;
    end else begin
      if (req0_rdy | req1_rdy) chk("one_hot_rdy", req0_rdy & req1_rdy, 0);
      if (!clk_en) chk("rdy_gated", {req0_rdy, req1_rdy}, 0);
      if (clk_en && req0_rdy) begin
        e = '{1'b0, pow5(req0_arg), en_cnt + 1};
        sb.push_back(e); glog.push_back(1'b0);
      end
      if (clk_en && req1_rdy) begin
        e = '{1'b1, pow5(req1_arg), en_cnt + 1};
        sb.push_back(e); glog.push_back(1'b1);
      end
      if (res_vld && !prev_vld) begin
        if (sb.size() == 0) chk("unexpected_res", res_vld, 0);
        else chk("latency_en_edges", en_cnt - sb[0].t, 4);
      end
      if (clk_en && res_vld && res_rdy) begin
        if (sb.size() == 0) chk("unexpected_xfer", res_vld, 0);
        else begin
          e = sb.pop_front();
          chk("sb_res_id", res_id, e.id);
          chk("sb_res", res, e.res);
        end
        rlog.push_back({res_id, res});
      end
      prev_vld <= res_vld;
    end
  end

  task automatic do_reset(input logic en);
    rst_n = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0; clk_en = en;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic id, input logic [W-1:0] a);
    bit got = 0;
    if (id) begin req1_vld = 1'b1; req1_arg = a; end
    else begin req0_vld = 1'b1; req0_arg = a; end
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = id ? req1_rdy : req0_rdy;
      @(posedge clk); #1;
    end
    if (!got) chk("timeout_rdy", id ? req1_rdy : req0_rdy, 1);
    if (id) req1_vld = 1'b0; else req0_vld = 1'b0;
  endtask

  // Returns on the falling edge where res_vld is first seen high.
  task automatic wait_res();
    bit got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (res_vld) begin got = 1; break; end
    end
    if (!got) chk("timeout_res", res_vld, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !res_vld) break;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    vec_t vt[6];
    int   gb, rb, t0;
    bit   seen;
    vt[0] = '{1'b0, 8'd0,   8'd0};
    vt[1] = '{1'b1, 8'd1,   8'd1};
    vt[2] = '{1'b0, 8'd6,   8'd96};
    vt[3] = '{1'b1, 8'd10,  8'd160};
    vt[4] = '{1'b0, 8'd128, 8'd0};
    vt[5] = '{1'b1, 8'd9,   8'd169};

    // Reset with clk_en low must still take effect.
    do_reset(1'b0);
    @(negedge clk);
    chk("rst_state", {res_vld, res_id, req0_rdy, req1_rdy, res}, 0);
    @(posedge clk); #1;
    clk_en = 1'b1; res_rdy = 1'b1;

    // Table-driven single-requester vectors.
    for (int i = 0; i < 6; i++) begin
      issue(vt[i].id, vt[i].arg);
      wait_res();
      chk("vec_res", res, vt[i].exp);
      chk("vec_id", res_id, vt[i].id);
      @(posedge clk); #1;
    end
    drain();

    // Lone requester 0, arg 3.
    do_reset(1'b1); res_rdy = 1'b1; gb = glog.size();
    issue(1'b0, 8'd3);
    wait_res();
    chk("r28_res", res, 8'd243);
    chk("r28_id", res_id, 0);
    @(negedge clk);
    chk("r28_one_cycle", res_vld, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("r28_rdy_pulses", glog.size() - gb, 1);

    // Both valid from reset: 0, 1, then 0 again.
    do_reset(1'b1); res_rdy = 1'b1; gb = glog.size(); rb = rlog.size();
    req0_arg = 8'd2; req1_arg = 8'd5; req0_vld = 1'b1; req1_vld = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (glog.size() - gb >= 3) break;
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    drain();
    chk("r29_grants", glog.size() - gb, 3);
    if (glog.size() - gb >= 3) begin
      chk("r29_g0", glog[gb], 0);
      chk("r29_g1", glog[gb+1], 1);
      chk("r29_g2", glog[gb+2], 0);
    end
    chk("r29_results", rlog.size() - rb, 3);
    if (rlog.size() - rb >= 3) begin
      chk("r29_r0", rlog[rb],   9'h020);
      chk("r29_r1", rlog[rb+1], 9'h135);
      chk("r29_r2", rlog[rb+2], 9'h020);
    end

    // Back-pressure in DONE for 10 cycles, req1 waiting.
    do_reset(1'b1); res_rdy = 1'b0;
    issue(1'b0, 8'd255);
    req1_arg = 8'd9; req1_vld = 1'b1;
    wait_res();
    for (int k = 0; k < 10; k++) begin
      chk("r30_hold", {res_vld, res_id, req0_rdy, req1_rdy, res}, {4'b1000, 8'd255});
      @(negedge clk);
    end
    @(posedge clk); #1; res_rdy = 1'b1;
    @(negedge clk);
    chk("r30_still_done", res_vld, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r30_vld_drop", res_vld, 0);
    chk("r30_idle_next", req1_rdy, 1);
    @(posedge clk); #1; req1_vld = 1'b0;
    drain();

    // clk_en stalls: in IDLE, in BUSY (3 cycles) and in DONE.
    do_reset(1'b1); res_rdy = 1'b0; clk_en = 1'b0;
    req0_arg = 8'd7; req0_vld = 1'b1; gb = glog.size();
    repeat (2) begin @(negedge clk); chk("r31_idle_en_low", req0_rdy, 0); end
    @(posedge clk); #1; clk_en = 1'b1;
    @(negedge clk);
    chk("r31_idle_en_high", req0_rdy, 1);
    t0 = cyc_n + 1;
    @(posedge clk); #1; req0_vld = 1'b0;
    @(posedge clk); #1; clk_en = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("r31_busy_frozen", res_vld, 0);
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    wait_res();
    chk("r31_late_by_3", cyc_n - t0, 7);
    chk("r31_res", res, 8'd167);
    chk("r31_grants", glog.size() - gb, 1);
    @(posedge clk); #1; clk_en = 1'b0; res_rdy = 1'b1;
    repeat (2) begin @(negedge clk); chk("r31_done_en_low", res_vld, 1); end
    @(posedge clk); #1; clk_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("r31_xfer_after_en", res_vld, 0);

    // Reset clears a previous result even with clk_en low.
    do_reset(1'b0);
    @(negedge clk);
    chk("rst_clears_res", {res_vld, res_id, res}, 0);
    @(posedge clk); #1; clk_en = 1'b1;

    // Reset pulse at cnt=2 aborts the operation.
    res_rdy = 1'b1;
    issue(1'b0, 8'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (res_vld) seen = 1; end
    chk("r32_no_aborted_res", seen, 0);
    @(posedge clk); #1;
    req0_arg = 8'd3; req1_arg = 8'd6; req0_vld = 1'b1; req1_vld = 1'b1;
    @(negedge clk);
    chk("r32_tie_to_0", {req0_rdy, req1_rdy}, 2'b10);
    @(posedge clk); #1; req0_vld = 1'b0; req1_vld = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
